// File: rtl/fht_frame_sched.sv
// fht_frame_sched
// Frame-level scheduler wrapped around fht_control and its four-bank,
// two-page RAM. It owns the RAM while a frame of N = 4*2^A_BIT samples is
// written from the input stream, starts fht_control, hands it the RAM,
// takes the RAM back once fht_control reports idle, and streams the result
// page out through a valid/ready port.
//
// Ports
//   iCLK, iRESET               clock, synchronous active-high reset
//   iDATA_VALID/iDATA          input stream, oDATA_READY is its ready
//   oFHT_START                 one-cycle start pulse to fht_control
//   iFHT_RDY, iRES_PAGE        fht_control idle flag and result page
//   oMUX_EXT                   1 = scheduler drives RAM, 0 = fht_control
//   oPAGE/oBANK_SEL/oBANK_ADDR RAM page, bank and bank address
//   oBANK_WE/oBANK_D           RAM write strobe and data
//   oBANK_RE/iBANK_Q           RAM read strobe, data one cycle later
//   oOUT_VALID/oOUT_DATA       result stream, iOUT_READY is its ready
//   oFRAME_DONE                pulse after the last result is accepted
//   oERR                       sticky watchdog error, cleared by next load
//   oBUSY                      low only when idle in LOAD with no samples
module fht_frame_sched #(
  parameter int A_BIT  = 8,
  parameter int D_BIT  = 16,
  parameter int WD_CYC = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iDATA_VALID,
  input  logic [D_BIT-1:0] iDATA,
  output logic             oDATA_READY,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  input  logic             iRES_PAGE,
  output logic             oMUX_EXT,
  output logic             oPAGE,
  output logic [1:0]       oBANK_SEL,
  output logic [A_BIT-1:0] oBANK_ADDR,
  output logic             oBANK_WE,
  output logic [D_BIT-1:0] oBANK_D,
  output logic             oBANK_RE,
  input  logic [D_BIT-1:0] iBANK_Q,
  output logic             oOUT_VALID,
  output logic [D_BIT-1:0] oOUT_DATA,
  input  logic             iOUT_READY,
  output logic             oFRAME_DONE,
  output logic             oERR,
  output logic             oBUSY
);

  localparam int N_BIT = A_BIT + 2;
  localparam int WD_W  = (WD_CYC > 1) ? $clog2(WD_CYC) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT_LOW,
    S_RUN,
    S_UNLOAD
  } state_t;

  state_t state, state_nx;

  logic [N_BIT-1:0] n;        // sample index: write index in LOAD, next read in UNLOAD
  logic [N_BIT-1:0] wr_idx;   // index of the write currently on the RAM port
  logic [WD_W-1:0]  wd;
  logic             cap;      // read issued last cycle, iBANK_Q valid now
  logic             rd_done;  // read of sample N-1 already issued

  logic accept, n_last, wd_exp, hs, rd_issue;

  assign oDATA_READY = (state == S_LOAD);
  assign accept      = iDATA_VALID & oDATA_READY;
  assign n_last      = (n == '1);
  assign wd_exp      = (wd == WD_W'(WD_CYC - 1));
  assign hs          = oOUT_VALID & iOUT_READY;
  assign oBUSY       = !((state == S_LOAD) && (n == '0));

  // The next read goes out combinationally in the handshake cycle so the
  // result port can sustain one sample every two cycles.
  assign rd_issue = (state == S_UNLOAD) & ~cap & ~rd_done & (~oOUT_VALID | iOUT_READY);
  assign oBANK_RE = rd_issue;

  // Reads address the live counter; writes use the registered index of the
  // accepted sample because n has already advanced by the write cycle.
  assign oBANK_SEL  = (state == S_UNLOAD) ? n[1:0]       : wr_idx[1:0];
  assign oBANK_ADDR = (state == S_UNLOAD) ? n[N_BIT-1:2] : wr_idx[N_BIT-1:2];

  always_ff @(posedge iCLK) begin
    if (iRESET) state <= S_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:     if (accept && n_last) state_nx = S_START;
      S_START:    state_nx = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!iFHT_RDY)   state_nx = S_RUN;
        else if (wd_exp) state_nx = S_LOAD;
      end
      S_RUN:      if (iFHT_RDY) state_nx = S_UNLOAD;
      S_UNLOAD:   if (hs && rd_done) state_nx = S_LOAD;
      default:    state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      n           <= '0;
      wr_idx      <= '0;
      wd          <= '0;
      cap         <= 1'b0;
      rd_done     <= 1'b0;
      oFHT_START  <= 1'b0;
      oMUX_EXT    <= 1'b1;
      oPAGE       <= 1'b0;
      oBANK_WE    <= 1'b0;
      oBANK_D     <= '0;
      oOUT_VALID  <= 1'b0;
      oOUT_DATA   <= '0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      oBANK_WE    <= 1'b0;
      oFHT_START  <= 1'b0;
      oFRAME_DONE <= 1'b0;
      cap         <= rd_issue;
      case (state)
        S_LOAD: begin
          if (accept) begin
            oBANK_WE <= 1'b1;
            oBANK_D  <= iDATA;
            wr_idx   <= n;
            n        <= n + 1'b1;
            oERR     <= 1'b0;
          end
        end
        S_START: begin
          oFHT_START <= 1'b1;
          oMUX_EXT   <= 1'b0;
          wd         <= '0;
        end
        S_WAIT_LOW: begin
          if (iFHT_RDY) begin
            if (wd_exp) begin
              oERR     <= 1'b1;
              oMUX_EXT <= 1'b1;
              n        <= '0;
            end else begin
              wd <= wd + 1'b1;
            end
          end
        end
        S_RUN: begin
          rd_done <= 1'b0;
          if (iFHT_RDY) begin
            oPAGE    <= iRES_PAGE;
            oMUX_EXT <= 1'b1;
          end
        end
        S_UNLOAD: begin
          if (rd_issue) begin
            n <= n + 1'b1;
            if (n_last) rd_done <= 1'b1;
          end
          if (cap) begin
            oOUT_DATA  <= iBANK_Q;
            oOUT_VALID <= 1'b1;
          end else if (hs) begin
            oOUT_VALID <= 1'b0;
            if (rd_done) begin
              oFRAME_DONE <= 1'b1;
              oPAGE       <= 1'b0;
              n           <= '0;
              rd_done     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_frame_sched.sv
module tb_fht_frame_sched;

  localparam int A_BIT  = 2;
  localparam int D_BIT  = 16;
  localparam int WD_CYC = 16;
  localparam int N      = 4 * (1 << A_BIT);

  logic             iCLK = 1'b0;
  logic             iRESET;
  logic             iDATA_VALID;
  logic [D_BIT-1:0] iDATA;
  logic             oDATA_READY;
  logic             oFHT_START;
  logic             iFHT_RDY;
  logic             iRES_PAGE;
  logic             oMUX_EXT;
  logic             oPAGE;
  logic [1:0]       oBANK_SEL;
  logic [A_BIT-1:0] oBANK_ADDR;
  logic             oBANK_WE;
  logic [D_BIT-1:0] oBANK_D;
  logic             oBANK_RE;
  logic [D_BIT-1:0] iBANK_Q;
  logic             oOUT_VALID;
  logic [D_BIT-1:0] oOUT_DATA;
  logic             iOUT_READY;
  logic             oFRAME_DONE;
  logic             oERR;
  logic             oBUSY;

  always #5 iCLK = ~iCLK;

  fht_frame_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT), .WD_CYC(WD_CYC)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iDATA_VALID(iDATA_VALID), .iDATA(iDATA),
    .oDATA_READY(oDATA_READY), .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY),
    .iRES_PAGE(iRES_PAGE), .oMUX_EXT(oMUX_EXT), .oPAGE(oPAGE),
    .oBANK_SEL(oBANK_SEL), .oBANK_ADDR(oBANK_ADDR), .oBANK_WE(oBANK_WE),
    .oBANK_D(oBANK_D), .oBANK_RE(oBANK_RE), .iBANK_Q(iBANK_Q),
    .oOUT_VALID(oOUT_VALID), .oOUT_DATA(oOUT_DATA), .iOUT_READY(iOUT_READY),
    .oFRAME_DONE(oFRAME_DONE), .oERR(oERR), .oBUSY(oBUSY)
  );

  int checks = 0;
  int errors = 0;
  int cc = 0;

  // Environment: RAM, fht_control stand-in and event logs.
  logic [D_BIT-1:0] mem [0:1][0:3][0:3];
  bit               fht_never = 0;
  logic             fht_page = 1'b0;
  logic [D_BIT-1:0] fht_key = '0;
  int               fcnt = 0;

  typedef struct {
    int         cyc;
    int         bank;
    int         addr;
    logic [D_BIT-1:0] d;
  } wr_t;

  logic [D_BIT-1:0] acc_q[$];
  int               acc_c[$];
  wr_t              wr_q[$];
  int               start_q[$];
  logic             start_mux_q[$];
  logic             start_pmux_q[$];
  logic [D_BIT-1:0] out_q[$];
  int               hs_c[$];
  logic             hs_page[$];
  int               fd_q[$];
  int               viol = 0;
  int               stall_viol = 0;
  int               run_rdy_viol = 0;
  logic             prev_mux = 1'b1;
  logic             prev_stall = 1'b0;
  logic [D_BIT-1:0] prev_data = '0;

  always @(posedge iCLK) begin
    if (oBANK_WE && oBANK_RE) viol++;
    if ((oBANK_WE || oBANK_RE) && !oMUX_EXT) viol++;
    if (iFHT_RDY === 1'b0 && oDATA_READY) run_rdy_viol++;
    if (iDATA_VALID && oDATA_READY && !iRESET) begin
      acc_q.push_back(iDATA);
      acc_c.push_back(cc);
    end
    if (oBANK_WE) wr_q.push_back('{cc, int'(oBANK_SEL), int'(oBANK_ADDR), oBANK_D});
    if (oFHT_START) begin
      start_q.push_back(cc);
      start_mux_q.push_back(oMUX_EXT);
      start_pmux_q.push_back(prev_mux);
    end
    prev_mux = oMUX_EXT;
    if (prev_stall && (!oOUT_VALID || oOUT_DATA !== prev_data)) stall_viol++;
    prev_stall = oOUT_VALID && !iOUT_READY && !iRESET;
    prev_data  = oOUT_DATA;
    if (oOUT_VALID && iOUT_READY) begin
      out_q.push_back(oOUT_DATA);
      hs_c.push_back(cc);
      hs_page.push_back(oPAGE);
    end
    if (oFRAME_DONE) fd_q.push_back(cc);

    if (oMUX_EXT && oBANK_WE) mem[oPAGE][oBANK_SEL][oBANK_ADDR] <= oBANK_D;
    if (oMUX_EXT && oBANK_RE) iBANK_Q <= mem[oPAGE][oBANK_SEL][oBANK_ADDR];

    // fht_control stand-in: RDY falls 3 cycles after the start pulse and
    // rises 40 cycles later with the frame, xored with a key, in fht_page.
    if (iRESET) begin
      iFHT_RDY  <= 1'b1;
      iRES_PAGE <= 1'b0;
      fcnt = 0;
    end else if (oFHT_START && !fht_never) begin
      fcnt = 1;
    end else if (fcnt != 0) begin
      if (fcnt == 2) iFHT_RDY <= 1'b0;
      if (fcnt == 42) begin
        iFHT_RDY  <= 1'b1;
        iRES_PAGE <= fht_page;
        for (int b = 0; b < 4; b++)
          for (int a = 0; a < 4; a++)
            mem[fht_page][b][a] <= mem[0][b][a] ^ fht_key;
        fcnt = 0;
      end else begin
        fcnt++;
      end
    end
    cc++;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete(); acc_c.delete(); wr_q.delete(); start_q.delete();
    start_mux_q.delete(); start_pmux_q.delete(); out_q.delete();
    hs_c.delete(); hs_page.delete(); fd_q.delete();
    viol = 0; stall_viol = 0; run_rdy_viol = 0;
  endtask

  task automatic do_reset();
    iRESET = 1'b1; iDATA_VALID = 1'b0; iDATA = '0; iOUT_READY = 1'b0;
    tick(); tick();
    iRESET = 1'b0;
    clear_logs();
  endtask

  task automatic feed(input bit seq, input int gap_pct, input bit hold_valid, output bit ok);
    int g = 0;
    while (acc_q.size() < N && g < 1000) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        iDATA_VALID = 1'b0;
        iDATA = D_BIT'($urandom);
      end else begin
        iDATA_VALID = 1'b1;
        iDATA = seq ? D_BIT'(acc_q.size()) : D_BIT'($urandom);
      end
      tick();
      g++;
    end
    iDATA_VALID = hold_valid;
    ok = (acc_q.size() == N);
  endtask

  task automatic unload(input int mode, output bit ok);
    int g = 0;
    while (fd_q.size() == 0 && g < 2000) begin
      iOUT_READY = (mode == 0) ? 1'b1 : ((g % 3) == 0);
      tick();
      g++;
    end
    iOUT_READY = 1'b0;
    ok = (fd_q.size() != 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({oMUX_EXT, oPAGE, oFHT_START, oBANK_WE, oBANK_RE, oOUT_VALID, oERR, oFRAME_DONE, oBUSY, oDATA_READY} !== 10'b1000000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b", {oMUX_EXT, oPAGE, oFHT_START, oBANK_WE, oBANK_RE, oOUT_VALID, oERR, oFRAME_DONE, oBUSY, oDATA_READY}, 10'b1000000001);
    end
    checks++;
    if ({oOUT_DATA, oBANK_D, oBANK_SEL, oBANK_ADDR} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {oOUT_DATA, oBANK_D, oBANK_SEL, oBANK_ADDR});
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    do_reset();
    fht_page = 1'b1; fht_key = '0;
    feed(1, 0, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_feed_timeout: got %0d accepts expected %0d", acc_q.size(), N); end
    unload(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_unload_timeout: got %0d results expected %0d", out_q.size(), N); end
    checks++;
    if (wr_q.size() != N) begin errors++; $display("FAIL basic_wr_count: got %0d expected %0d", wr_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (wr_q[k].bank != k % 4 || wr_q[k].addr != k / 4 || wr_q[k].d !== D_BIT'(k)) begin
        errors++;
        $display("FAIL basic_wr_map[%0d]: got bank %0d addr %0d data %0d expected bank %0d addr %0d data %0d",
                 k, wr_q[k].bank, wr_q[k].addr, wr_q[k].d, k % 4, k / 4, k);
      end
    end
    checks++;
    if (start_q.size() != 1) begin errors++; $display("FAIL basic_start_count: got %0d expected 1", start_q.size()); end
    checks++;
    if (start_q[0] != acc_c[N-1] + 2) begin errors++; $display("FAIL basic_start_cycle: got %0d expected %0d", start_q[0], acc_c[N-1] + 2); end
    checks++;
    if (start_mux_q[0] !== 1'b0 || start_pmux_q[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_mux_with_pulse: got before %b during %b expected before 1 during 0", start_pmux_q[0], start_mux_q[0]);
    end
    checks++;
    if (out_q.size() != N) begin errors++; $display("FAIL basic_out_count: got %0d expected %0d", out_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_q[k] !== D_BIT'(k) || hs_page[k] !== 1'b1) begin
        errors++;
        $display("FAIL basic_out[%0d]: got data %0d page %b expected data %0d page 1", k, out_q[k], hs_page[k], k);
      end
    end
    checks++;
    if (fd_q.size() != 1 || fd_q[0] != hs_c[N-1] + 1) begin
      errors++;
      $display("FAIL basic_frame_done: got count %0d cycle %0d expected count 1 cycle %0d", fd_q.size(), fd_q[0], hs_c[N-1] + 1);
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL basic_port_rules: got %0d violations expected 0", viol); end
    tick();
    checks++;
    if (oPAGE !== 1'b0 || oBUSY !== 1'b0) begin errors++; $display("FAIL basic_back_to_load: got page %b busy %b expected 0 0", oPAGE, oBUSY); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    fht_page = 1'($urandom_range(1)); fht_key = D_BIT'($urandom);
    feed(0, 0, 0, ok);
    unload(1, ok);
    checks++;
    if (!ok || out_q.size() != N) begin errors++; $display("FAIL bp_out_count: got %0d expected %0d", out_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_q[k] !== (acc_q[k] ^ fht_key) || hs_page[k] !== fht_page) begin
        errors++;
        $display("FAIL bp_out[%0d]: got data %h page %b expected data %h page %b", k, out_q[k], hs_page[k], acc_q[k] ^ fht_key, fht_page);
      end
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d changes expected 0", stall_viol); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL bp_port_rules: got %0d violations expected 0", viol); end
  endtask

  task automatic test_gaps_run_valid();
    bit ok, seen_low;
    int g;
    do_reset();
    fht_page = 1'b0; fht_key = D_BIT'($urandom);
    feed(0, 40, 1, ok);
    seen_low = 0; g = 0;
    while (!(seen_low && iFHT_RDY) && g < 200) begin
      if (!iFHT_RDY) seen_low = 1;
      tick();
      g++;
    end
    iDATA_VALID = 1'b0;
    unload(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL gap_unload_timeout: got %0d results expected %0d", out_q.size(), N); end
    checks++;
    if (acc_q.size() != N || wr_q.size() != N) begin
      errors++;
      $display("FAIL gap_counts: got %0d accepts %0d writes expected %0d %0d", acc_q.size(), wr_q.size(), N, N);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (wr_q[k].cyc != acc_c[k] + 1 || wr_q[k].d !== acc_q[k] || wr_q[k].bank != k % 4 || wr_q[k].addr != k / 4) begin
        errors++;
        $display("FAIL gap_wr[%0d]: got cycle %0d data %h expected cycle %0d data %h", k, wr_q[k].cyc, wr_q[k].d, acc_c[k] + 1, acc_q[k]);
      end
    end
    checks++;
    if (run_rdy_viol != 0) begin errors++; $display("FAIL gap_ready_in_run: got %0d cycles expected 0", run_rdy_viol); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_q[k] !== (acc_q[k] ^ fht_key)) begin
        errors++;
        $display("FAIL gap_out[%0d]: got %h expected %h", k, out_q[k], acc_q[k] ^ fht_key);
      end
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int g;
    do_reset();
    fht_never = 1;
    feed(1, 0, 0, ok);
    g = 0;
    while (start_q.size() == 0 && g < 20) begin tick(); g++; end
    g = 0;
    while (oERR !== 1'b1 && g < 100) begin tick(); g++; end
    checks++;
    if (start_q.size() != 1 || cc - start_q[0] != WD_CYC) begin
      errors++;
      $display("FAIL wd_err_delay: got %0d cycles expected %0d", cc - start_q[0], WD_CYC);
    end
    checks++;
    if (oMUX_EXT !== 1'b1 || oDATA_READY !== 1'b1 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL wd_back_to_load: got mux %b ready %b busy %b expected 1 1 0", oMUX_EXT, oDATA_READY, oBUSY);
    end
    tick(); tick(); tick();
    checks++;
    if (oERR !== 1'b1) begin errors++; $display("FAIL wd_err_sticky: got %b expected 1", oERR); end
    iDATA_VALID = 1'b1; iDATA = D_BIT'($urandom);
    tick();
    iDATA_VALID = 1'b0;
    checks++;
    if (oERR !== 1'b0 || oBUSY !== 1'b1) begin errors++; $display("FAIL wd_err_clear: got err %b busy %b expected 0 1", oERR, oBUSY); end
    fht_never = 0;
  endtask

  task automatic test_reset_run();
    bit ok;
    int g;
    do_reset();
    fht_page = 1'b1; fht_key = D_BIT'($urandom);
    feed(0, 0, 0, ok);
    g = 0;
    while (iFHT_RDY !== 1'b0 && g < 50) begin tick(); g++; end
    tick(); tick(); tick();
    iRESET = 1'b1;
    tick();
    iRESET = 1'b0;
    checks++;
    if ({oMUX_EXT, oPAGE, oFHT_START, oBANK_WE, oBANK_RE, oOUT_VALID, oERR, oFRAME_DONE, oBUSY, oDATA_READY} !== 10'b1000000001) begin
      errors++;
      $display("FAIL rst_run_ctrl: got %b expected %b", {oMUX_EXT, oPAGE, oFHT_START, oBANK_WE, oBANK_RE, oOUT_VALID, oERR, oFRAME_DONE, oBUSY, oDATA_READY}, 10'b1000000001);
    end
    clear_logs();
    feed(0, 20, 0, ok);
    unload(0, ok);
    checks++;
    if (!ok || out_q.size() != N) begin errors++; $display("FAIL rst_run_recover_count: got %0d expected %0d", out_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_q[k] !== (acc_q[k] ^ fht_key)) begin
        errors++;
        $display("FAIL rst_run_out[%0d]: got %h expected %h", k, out_q[k], acc_q[k] ^ fht_key);
      end
    end
  endtask

  task automatic test_reset_unload();
    bit ok;
    int g;
    do_reset();
    fht_page = 1'b1; fht_key = D_BIT'($urandom) | 16'h0101;
    feed(0, 0, 0, ok);
    iOUT_READY = 1'b1;
    g = 0;
    while (out_q.size() < 5 && g < 200) begin tick(); g++; end
    iOUT_READY = 1'b0;
    tick();
    iRESET = 1'b1;
    tick();
    iRESET = 1'b0;
    checks++;
    if ({oMUX_EXT, oPAGE, oFHT_START, oBANK_WE, oBANK_RE, oOUT_VALID, oERR, oFRAME_DONE, oBUSY, oDATA_READY} !== 10'b1000000001) begin
      errors++;
      $display("FAIL rst_unl_ctrl: got %b expected %b", {oMUX_EXT, oPAGE, oFHT_START, oBANK_WE, oBANK_RE, oOUT_VALID, oERR, oFRAME_DONE, oBUSY, oDATA_READY}, 10'b1000000001);
    end
    checks++;
    if (oOUT_DATA !== '0) begin errors++; $display("FAIL rst_unl_data: got %h expected 0", oOUT_DATA); end
    clear_logs();
    fht_page = 1'b0;
    feed(0, 0, 0, ok);
    unload(1, ok);
    checks++;
    if (!ok || out_q.size() != N) begin errors++; $display("FAIL rst_unl_recover_count: got %0d expected %0d", out_q.size(), N); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_q[k] !== (acc_q[k] ^ fht_key) || hs_page[k] !== 1'b0) begin
        errors++;
        $display("FAIL rst_unl_out[%0d]: got %h page %b expected %h page 0", k, out_q[k], hs_page[k], acc_q[k] ^ fht_key);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_gaps_run_valid();
    test_watchdog();
    test_reset_run();
    test_reset_unload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
